// File: rtl/mux16_rr_arbiter_if.sv
// Bundle between the requesting datapath units and mux16_rr_arbiter.
// The master side drives requests, release and the shared mux output bit;
// the slave side (the arbiter) returns select, grant and status.
// Optional: MUX16_RR_ARB_LOCK_EN adds the 'lock' signal.
interface mux16_rr_arbiter_if;
   logic [15:0] req;
   logic        done;
   logic        f_in;
   logic [3:0]  sel;
   logic [15:0] grant;
   logic        busy;
   logic        f_q;
   logic        timeout;
`ifdef MUX16_RR_ARB_LOCK_EN
   logic        lock;

   modport master (
      output req, done, f_in, lock,
      input  sel, grant, busy, f_q, timeout
   );

   modport slave (
      input  req, done, f_in, lock,
      output sel, grant, busy, f_q, timeout
   );
`else
   modport master (
      output req, done, f_in,
      input  sel, grant, busy, f_q, timeout
   );

   modport slave (
      input  req, done, f_in,
      output sel, grant, busy, f_q, timeout
   );
`endif
endinterface

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter sharing one 16:1 single-bit mux among 16 requesters.
// Drives the mux select for the owner, holds the grant until release or
// HOLD_MAX cycles, and registers the mux output bit while busy.
// Optional: MUX16_RR_ARB_LOCK_EN adds a lock input that suppresses the
// hold timeout while asserted.
module mux16_rr_arbiter #(
   parameter int unsigned HOLD_MAX = 8,
   parameter int unsigned CNT_W    = 3
) (
   input  logic               clk_i,
   input  logic               rst_i,
   mux16_rr_arbiter_if.slave  bus
);

   typedef enum logic {
      ST_IDLE,
      ST_BUSY
   } state_e;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

   state_e           state_q, state_d;
   logic [3:0]       sel_q, sel_d;
   logic [3:0]       last_q, last_d;
   logic [15:0]      grant_q, grant_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             fq_q, fq_d;
   logic             to_q, to_d;

   logic [3:0]       pick;
   logic [3:0]       idx;
   logic             pick_vld;
   logic             lock_act;
   logic             rel_norm;
   logic             rel_force;

`ifdef MUX16_RR_ARB_LOCK_EN
   assign lock_act = bus.lock;
`else
   assign lock_act = 1'b0;
`endif

   // Normal release has priority over the forced one, so a done on the
   // last hold cycle never raises timeout.
   assign rel_norm  = bus.done || !bus.req[sel_q];
   assign rel_force = (cnt_q == CNT_LAST) && !lock_act;

   // Round-robin pick: first request scanning last+1, last+2, ... mod 16.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int unsigned k = 1; k <= 16; k++) begin
         // 4-bit add wraps; k=16 lands back on last itself
         idx = last_q + 4'(k);
         if (!pick_vld && bus.req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         sel_q   <= '0;
         last_q  <= 4'hF;
         grant_q <= '0;
         cnt_q   <= '0;
         fq_q    <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         sel_q   <= sel_d;
         last_q  <= last_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         fq_q    <= fq_d;
         to_q    <= to_d;
      end
   end

   // Next-state: grant from IDLE on any request, leave BUSY on release.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (pick_vld) state_d = ST_BUSY;
         ST_BUSY: if (rel_norm || rel_force) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output/datapath next values: select, grant, hold counter, sample, pulse.
   always_comb begin
      sel_d   = sel_q;
      last_d  = last_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      fq_d    = fq_q;
      to_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pick_vld) begin
               sel_d   = pick;
               last_d  = pick;
               grant_d = 16'(1) << pick;
               cnt_d   = '0;
            end
         end
         ST_BUSY: begin
            fq_d = bus.f_in;
            if (lock_act && (cnt_q == CNT_LAST))
               cnt_d = cnt_q;
            else
               cnt_d = cnt_q + CNT_W'(1);
            if (rel_norm) begin
               grant_d = '0;
            end else if (rel_force) begin
               grant_d = '0;
               to_d    = 1'b1;
            end
         end
         default: ;
      endcase
   end

   assign bus.sel     = sel_q;
   assign bus.grant   = grant_q;
   assign bus.busy    = (state_q == ST_BUSY);
   assign bus.f_q     = fq_q;
   assign bus.timeout = to_q;

   a_grant_onehot0 : assert property (@(posedge clk_i) disable iff (rst_i)
      $onehot0(grant_q));
   a_grant_iff_busy : assert property (@(posedge clk_i) disable iff (rst_i)
      ((grant_q != '0) == (state_q == ST_BUSY)));
   a_sel_matches : assert property (@(posedge clk_i) disable iff (rst_i)
      (state_q == ST_BUSY) |-> (grant_q == (16'(1) << sel_q)));

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Randomized bench for mux16_rr_arbiter against a behavioural reference
// model, preceded by directed scenarios for reset, first grant, rotation,
// hold timeout and reset while busy.
module tb_mux16_rr_arbiter;

   localparam int HOLD_MAX = 8;

   logic clk = 1'b0;
   logic rst;
   logic lock_v;

   always #5 clk = ~clk;

   mux16_rr_arbiter_if bus ();

   mux16_rr_arbiter #(.HOLD_MAX(HOLD_MAX), .CNT_W(3)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int n_vec = 0;
   int n_bad = 0;

   // reference model state
   bit m_busy;
   int m_sel;
   int m_owner;
   int m_last;
   int m_cnt;
   bit m_to;
   bit m_fq;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive(input logic r, input logic [15:0] q, input logic d,
                        input logic f, input logic lk);
      rst      = r;
      bus.req  = q;
      bus.done = d;
      bus.f_in = f;
`ifdef MUX16_RR_ARB_LOCK_EN
      lock_v   = lk;
      bus.lock = lk;
`else
      lock_v   = 1'b0 & lk;
`endif
   endtask

   function automatic int rr_pick(input int last, input logic [15:0] r);
      for (int k = 1; k <= 16; k++) begin
         int i;
         i = (last + k) % 16;
         if (r[i]) return i;
      end
      return -1;
   endfunction

   task automatic model_step();
      if (rst) begin
         m_busy = 0; m_sel = 0; m_owner = 0; m_last = 15;
         m_cnt = 0;  m_to = 0;  m_fq = 0;
      end else if (!m_busy) begin
         m_to = 0;
         if (bus.req != 16'h0) begin
            m_owner = rr_pick(m_last, bus.req);
            m_sel   = m_owner;
            m_last  = m_owner;
            m_busy  = 1;
            m_cnt   = 0;
         end
      end else begin
         m_fq = bus.f_in;
         m_to = 0;
         if (bus.done || !bus.req[m_owner]) begin
            m_busy = 0;
         end else if (m_cnt == HOLD_MAX - 1 && !lock_v) begin
            m_busy = 0;
            m_to   = 1;
         end else if (!(lock_v && m_cnt == HOLD_MAX - 1)) begin
            m_cnt = m_cnt + 1;
         end
      end
   endtask

   task automatic check_all();
      logic [15:0] exp_g;
      exp_g = m_busy ? (16'h1 << m_sel) : 16'h0;
      check("grant",   bus.grant,   exp_g);
      check("sel",     bus.sel,     m_sel);
      check("busy",    bus.busy,    m_busy);
      check("f_q",     bus.f_q,     m_fq);
      check("timeout", bus.timeout, m_to);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   initial begin : stim
      int nb;
      int exp_own[4];
      logic [15:0] rq;
      bit lk;
      exp_own = '{0, 8, 15, 0};

      // 1: reset
      drive(1, 16'h0000, 0, 0, 0);
      cycle(); cycle();
      check("t1_grant", bus.grant, 16'h0);
      check("t1_busy",  bus.busy, 1'b0);

      // 2: single requester, f_in sampled, release by done
      drive(0, 16'h0001, 0, 1, 0);
      cycle();
      check("t2_grant", bus.grant, 16'h0001);
      cycle(); cycle();
      check("t2_fq", bus.f_q, 1'b1);
      drive(0, 16'h0001, 1, 1, 0);
      cycle();
      check("t2_release", bus.busy, 1'b0);
      drive(0, 16'h0000, 0, 0, 0);
      cycle();

      // 3: rotation 0,8,15,0
      drive(1, 16'h0000, 0, 0, 0);
      cycle();
      for (int i = 0; i < 4; i++) begin
         drive(0, 16'h8101, 0, 0, 0);
         cycle();
         check("t3_owner", bus.sel, exp_own[i]);
         drive(0, 16'h8101, 1, 0, 0);
         cycle();
         check("t3_idle", bus.busy, 1'b0);
      end

      // 4: hold timeout and re-grant
      drive(1, 16'h0000, 0, 0, 0);
      cycle();
      drive(0, 16'h0010, 0, 1, 0);
      cycle();
      nb = 0;
      while (bus.busy && nb < 20) begin
         nb++;
         cycle();
      end
      check("t4_hold", nb, HOLD_MAX);
      check("t4_timeout", bus.timeout, 1'b1);
      cycle();
      check("t4_regrant", bus.grant, 16'h0010);
      check("t4_pulse", bus.timeout, 1'b0);

      // 5: reset while owner 3 is busy
      drive(1, 16'h0000, 0, 0, 0);
      cycle();
      drive(0, 16'h0008, 0, 1, 0);
      cycle();
      for (int i = 0; i < 5; i++) cycle();
      drive(1, 16'h0008, 0, 1, 0);
      cycle();
      check("t5_grant", bus.grant, 16'h0);
      check("t5_to", bus.timeout, 1'b0);
      drive(0, 16'h0009, 0, 0, 0);
      cycle();
      check("t5_first", bus.sel, 4'd0);
      drive(0, 16'h0000, 1, 0, 0);
      cycle();

`ifdef MUX16_RR_ARB_LOCK_EN
      // 6: lock suppresses timeout, releasing lock at the limit forces release
      drive(1, 16'h0000, 0, 0, 0);
      cycle();
      drive(0, 16'h0004, 0, 0, 1);
      for (int i = 0; i < 20; i++) cycle();
      check("t6_busy", bus.busy, 1'b1);
      drive(0, 16'h0004, 0, 0, 0);
      cycle();
      check("t6_release", bus.busy, 1'b0);
      check("t6_timeout", bus.timeout, 1'b1);
`endif

      // randomized segments of held request patterns
      drive(1, 16'h0000, 0, 0, 0);
      cycle();
      for (int s = 0; s < 150; s++) begin
         case ($urandom % 4)
            0: rq = 16'h1 << ($urandom % 16);
            1: rq = 16'($urandom & $urandom & $urandom);
            2: rq = 16'($urandom);
            default: rq = 16'h0;
         endcase
         lk = ($urandom % 3 == 0);
         for (int c = 0, n = $urandom_range(1, 25); c < n; c++) begin
            if ($urandom % 16 == 0) rq = rq ^ (16'h1 << ($urandom % 16));
            if ($urandom % 12 == 0) lk = ~lk;
            drive($urandom % 100 == 0, rq, $urandom % 10 == 0, 1'($urandom), lk);
            cycle();
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
